top_k_selector: RTL and testbench



---
 rtl/topk_pkg.sv | 21 ++
 rtl/topk_insert_network.sv | 63 ++++++
 rtl/top_k_selector.sv | 165 ++++++++++++++++
 tb/tb_top_k_selector.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/topk_pkg.sv
// Shared types and constants for the streaming top-K selector.
// Sentinels mark empty result slots.
package topk_pkg;

  localparam int SCORE_W = 32;
  localparam int INDEX_W = 32;

  typedef logic signed [SCORE_W-1:0] score_t;
  typedef logic [INDEX_W-1:0] index_t;

  localparam score_t SCORE_SENTINEL = 32'sh8000_0000;
  localparam index_t INDEX_SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUBLISH,
    DONE
  } topk_state_t;

endpackage

// File: rtl/topk_insert_network.sv
// Combinational sorted-insert step: compare candidate with every
// slot, pick the first displaceable one, shift the tail down.
module topk_insert_network
  import topk_pkg::*;
#(
  parameter int TOP_K       = 5,
  parameter int SCORE_WIDTH = 32,
  parameter int INDEX_WIDTH = 32
) (
  input  logic [TOP_K-1:0][SCORE_WIDTH-1:0] list_score,
  input  logic [TOP_K-1:0][INDEX_WIDTH-1:0] list_index,
  input  logic [TOP_K-1:0]                  list_valid,
  input  logic [SCORE_WIDTH-1:0]            cand_score,
  input  logic [INDEX_WIDTH-1:0]            cand_index,
  output logic [TOP_K-1:0][SCORE_WIDTH-1:0] next_score,
  output logic [TOP_K-1:0][INDEX_WIDTH-1:0] next_index,
  output logic [TOP_K-1:0]                  next_valid
);

  logic [TOP_K-1:0] disp;
  logic [TOP_K-1:0] first;

  // Strictly-less keeps equal scores in arrival order.
  always_comb begin : cmp
    for (int i = 0; i < TOP_K; i++) begin
      disp[i] = !list_valid[i] ||
        ($signed(list_score[i]) < $signed(cand_score));
    end
  end

  always_comb begin : prio
    logic found;
    found = 1'b0;
    first = '0;
    for (int i = 0; i < TOP_K; i++) begin
      if (disp[i] && !found) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin : shift
    logic seen;
    seen       = 1'b0;
    next_score = list_score;
    next_index = list_index;
    next_valid = list_valid;
    for (int i = 0; i < TOP_K; i++) begin
      if (first[i]) begin
        next_score[i] = cand_score;
        next_index[i] = cand_index;
        next_valid[i] = 1'b1;
      end else if (seen) begin
        next_score[i] = list_score[(i > 0) ? i - 1 : 0];
        next_index[i] = list_index[(i > 0) ? i - 1 : 0];
        next_valid[i] = list_valid[(i > 0) ? i - 1 : 0];
      end
      seen = seen | first[i];
    end
  end

endmodule

// File: rtl/top_k_selector.sv
// Streaming top-K selector: keeps the K best (score, index) beats
// and publishes them on frozen registers at end of stream.
module top_k_selector
  import topk_pkg::*;
#(
  parameter int TOP_K       = 5,
  parameter int SCORE_WIDTH = 32,
  parameter int INDEX_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [31:0]                       num_candidates,
  input  logic                              score_valid,
  output logic                              score_ready,
  input  logic [SCORE_WIDTH-1:0]            score_data,
  input  logic [INDEX_WIDTH-1:0]            score_index,
  input  logic                              score_last,
  output logic [TOP_K-1:0][SCORE_WIDTH-1:0] similarity_scores,
  output logic [TOP_K-1:0][INDEX_WIDTH-1:0] doc_indices,
  output logic [$clog2(TOP_K+1)-1:0]        valid_count,
  output logic                              busy,
  output logic                              done,
  output logic                              count_mismatch
);

  localparam int CW = $clog2(TOP_K + 1);
  localparam logic [SCORE_WIDTH-1:0] S_SENT =
    {1'b1, {(SCORE_WIDTH-1){1'b0}}};
  localparam logic [INDEX_WIDTH-1:0] I_SENT = '1;

  topk_state_t state_q, state_d;

  logic [TOP_K-1:0][SCORE_WIDTH-1:0] wl_score_q, wl_score_d;
  logic [TOP_K-1:0][INDEX_WIDTH-1:0] wl_index_q, wl_index_d;
  logic [TOP_K-1:0]                  wl_valid_q, wl_valid_d;
  logic [TOP_K-1:0][SCORE_WIDTH-1:0] ins_score;
  logic [TOP_K-1:0][INDEX_WIDTH-1:0] ins_index;
  logic [TOP_K-1:0]                  ins_valid;

  logic [TOP_K-1:0][SCORE_WIDTH-1:0] pub_score_q, pub_score_d;
  logic [TOP_K-1:0][INDEX_WIDTH-1:0] pub_index_q, pub_index_d;
  logic [CW-1:0]                     vcnt_q, vcnt_d;
  logic [31:0]                       acc_q, acc_d;
  logic [31:0]                       num_q, num_d;
  logic                              done_q, done_d;
  logic                              mism_q, mism_d;

  logic start_ok;
  logic beat_ok;

  assign start_ok = start &&
    (state_q == IDLE || state_q == DONE);
  assign beat_ok = score_valid && score_ready;

  topk_insert_network #(
    .TOP_K      (TOP_K),
    .SCORE_WIDTH(SCORE_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_ins (
    .list_score(wl_score_q),
    .list_index(wl_index_q),
    .list_valid(wl_valid_q),
    .cand_score(score_data),
    .cand_index(score_index),
    .next_score(ins_score),
    .next_index(ins_index),
    .next_valid(ins_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (num_candidates == 32'd0) ?
            PUBLISH : COLLECT;
        end
      end
      COLLECT: if (beat_ok && score_last) state_d = PUBLISH;
      PUBLISH: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    score_ready = (state_q == COLLECT);
    busy = (state_q == COLLECT) || (state_q == PUBLISH);
  end

  always_comb begin
    wl_score_d  = wl_score_q;
    wl_index_d  = wl_index_q;
    wl_valid_d  = wl_valid_q;
    pub_score_d = pub_score_q;
    pub_index_d = pub_index_q;
    vcnt_d      = vcnt_q;
    acc_d       = acc_q;
    num_d       = num_q;
    done_d      = done_q;
    mism_d      = mism_q;
    if (start_ok) begin
      wl_score_d = {TOP_K{S_SENT}};
      wl_index_d = {TOP_K{I_SENT}};
      wl_valid_d = '0;
      acc_d      = 32'd0;
      num_d      = num_candidates;
      done_d     = 1'b0;
      mism_d     = 1'b0;
    end else if (beat_ok) begin
      wl_score_d = ins_score;
      wl_index_d = ins_index;
      wl_valid_d = ins_valid;
      acc_d = (acc_q == '1) ? acc_q : acc_q + 32'd1;
    end
    if (state_q == PUBLISH) begin
      pub_score_d = wl_score_q;
      pub_index_d = wl_index_q;
      vcnt_d      = '0;
      for (int i = 0; i < TOP_K; i++) begin
        vcnt_d = vcnt_d + CW'(wl_valid_q[i]);
      end
      mism_d = (acc_q != num_q);
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wl_score_q  <= {TOP_K{S_SENT}};
      wl_index_q  <= {TOP_K{I_SENT}};
      wl_valid_q  <= '0;
      pub_score_q <= {TOP_K{S_SENT}};
      pub_index_q <= {TOP_K{I_SENT}};
      vcnt_q      <= '0;
      acc_q       <= '0;
      num_q       <= '0;
      done_q      <= 1'b0;
      mism_q      <= 1'b0;
    end else begin
      wl_score_q  <= wl_score_d;
      wl_index_q  <= wl_index_d;
      wl_valid_q  <= wl_valid_d;
      pub_score_q <= pub_score_d;
      pub_index_q <= pub_index_d;
      vcnt_q      <= vcnt_d;
      acc_q       <= acc_d;
      num_q       <= num_d;
      done_q      <= done_d;
      mism_q      <= mism_d;
    end
  end

  assign similarity_scores = pub_score_q;
  assign doc_indices       = pub_index_q;
  assign valid_count       = vcnt_q;
  assign done              = done_q;
  assign count_mismatch    = mism_q;

endmodule

// File: tb/tb_top_k_selector.sv
// Bench for top_k_selector: directed plan plus random streams
// scored against a select-the-max reference over all beats.
module tb_top_k_selector;

  localparam int K  = 5;
  localparam int SW = 32;
  localparam int IW = 32;
  localparam int CW = $clog2(K + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [31:0]             num_candidates;
  logic                    score_valid;
  logic                    score_ready;
  logic [SW-1:0]           score_data;
  logic [IW-1:0]           score_index;
  logic                    score_last;
  logic [K-1:0][SW-1:0]    similarity_scores;
  logic [K-1:0][IW-1:0]    doc_indices;
  logic [CW-1:0]           valid_count;
  logic                    busy;
  logic                    done;
  logic                    count_mismatch;

  int errors = 0;
  int checks = 0;
  int exp_vc = 0;

  int          sc_in[$];
  int unsigned ix_in[$];
  int          mq_s[$];
  int unsigned mq_i[$];

  top_k_selector #(
    .TOP_K      (K),
    .SCORE_WIDTH(SW),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_candidates   (num_candidates),
    .score_valid      (score_valid),
    .score_ready      (score_ready),
    .score_data       (score_data),
    .score_index      (score_index),
    .score_last       (score_last),
    .similarity_scores(similarity_scores),
    .doc_indices      (doc_indices),
    .valid_count      (valid_count),
    .busy             (busy),
    .done             (done),
    .count_mismatch   (count_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", score_ready, 0);
    check("rst_vc", valid_count, 0);
    check("rst_mism", count_mismatch, 0);
    for (int k = 0; k < K; k++) begin
      check($sformatf("rst_score[%0d]", k),
            similarity_scores[k], 64'h8000_0000);
      check($sformatf("rst_index[%0d]", k),
            doc_indices[k], 64'hFFFF_FFFF);
    end
  endtask

  // Reference: rank every accepted beat, best first, earliest on ties.
  task automatic check_result(input int n);
    bit          taken[];
    int          best;
    int          nv;
    logic [31:0] es;
    logic [31:0] ei;
    taken = new[mq_s.size()];
    nv = (mq_s.size() < K) ? mq_s.size() : K;
    for (int k = 0; k < K; k++) begin
      best = -1;
      for (int j = 0; j < mq_s.size(); j++) begin
        if (!taken[j] && (best < 0 || mq_s[j] > mq_s[best]))
          best = j;
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        es = mq_s[best];
        ei = mq_i[best];
      end else begin
        es = 32'h8000_0000;
        ei = 32'hFFFF_FFFF;
      end
      check($sformatf("score[%0d]", k), similarity_scores[k], es);
      check($sformatf("index[%0d]", k), doc_indices[k], ei);
    end
    check("valid_count", valid_count, nv);
    check("count_mismatch", count_mismatch,
          (mq_s.size() != n) ? 1 : 0);
    exp_vc = nv;
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    num_candidates = n;
    @(negedge clk);
    start = 1'b0;
    mq_s.delete();
    mq_i.delete();
    check("start_done_clr", done, 0);
    check("start_mism_clr", count_mismatch, 0);
    check("start_vc_hold", valid_count, exp_vc);
    check("start_busy", busy, 1);
  endtask

  task automatic run(input int n, input bit hold,
                     input bit gaps, input bit poke);
    start_run(n);
    foreach (sc_in[b]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          score_valid = 1'b0;
          check("gap_rdy", score_ready, 1);
          @(negedge clk);
        end
      end
      score_valid = 1'b1;
      score_data  = sc_in[b];
      score_index = ix_in[b];
      score_last  = (b == sc_in.size() - 1);
      if (poke && b == 0) begin
        start = 1'b1;
        num_candidates = 32'd99;
      end
      check("beat_rdy", score_ready, 1);
      mq_s.push_back(sc_in[b]);
      mq_i.push_back(ix_in[b]);
      @(negedge clk);
      start = 1'b0;
    end
    if (hold) begin
      score_valid = 1'b1;
      score_data  = 32'd1000;
      score_index = 32'd999;
      score_last  = 1'b1;
    end else begin
      score_valid = 1'b0;
      score_last  = 1'b0;
    end
    check("pub_done", done, 0);
    check("pub_busy", busy, 1);
    check("pub_rdy", score_ready, 0);
    @(negedge clk);
    check("done_2cyc", done, 1);
    check("done_busy", busy, 0);
    if (hold) begin
      repeat (2) begin
        check("done_rdy", score_ready, 0);
        @(negedge clk);
      end
    end
    check_result(n);
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_candidates = '0;
    score_valid = 1'b0;
    score_data = '0;
    score_index = '0;
    score_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    sc_in = '{10, 50, 30, 70, 20, 60};
    ix_in = '{0, 1, 2, 3, 4, 5};
    run(6, 1'b0, 1'b0, 1'b0);

    sc_in = '{5, -3, 9};
    ix_in = '{11, 12, 13};
    run(3, 1'b0, 1'b0, 1'b0);

    sc_in = '{40, 40, 40, 41};
    ix_in = '{7, 2, 9, 4};
    run(4, 1'b0, 1'b0, 1'b0);

    score_valid = 1'b1;
    score_data  = 32'd1000;
    score_index = 32'd999;
    score_last  = 1'b1;
    repeat (2) begin
      check("done_hold_rdy", score_ready, 0);
      @(negedge clk);
    end
    sc_in = '{8, 100, -7};
    ix_in = '{31, 32, 33};
    run(4, 1'b1, 1'b0, 1'b0);

    sc_in.delete();
    ix_in.delete();
    run(0, 1'b0, 1'b0, 1'b0);

    sc_in = '{3, 4};
    ix_in = '{41, 42};
    run(2, 1'b0, 1'b0, 1'b1);

    sc_in.delete();
    start_run(8);
    for (int b = 0; b < 4; b++) begin
      score_valid = 1'b1;
      score_data  = $urandom;
      score_index = $urandom;
      score_last  = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    score_valid = 1'b0;
    exp_vc = 0;
    @(negedge clk);
    sc_in = '{1, 2};
    ix_in = '{50, 51};
    run(2, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int nb;
      int n;
      nb = int'($urandom_range(1, 12));
      n  = nb;
      if ($urandom_range(0, 3) == 0)
        n = nb + int'($urandom_range(0, 2)) - 1;
      if (n == 0) n = 1;
      sc_in.delete();
      ix_in.delete();
      for (int j = 0; j < nb; j++) begin
        case ($urandom_range(0, 3))
          0:       sc_in.push_back(int'($urandom));
          1:       sc_in.push_back(int'(32'h8000_0000));
          default: sc_in.push_back(int'($urandom_range(0, 20)) - 10);
        endcase
        ix_in.push_back($urandom);
      end
      run(n, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
